// File: rtl/mem_access_lsu_pkg.sv
// Shared encodings for the memory-access stage: funct3 access sizes and the wait-FSM states.
// Latency: n/a (package).  Backpressure: n/a.
// Imported by the LSU top; the byte-lane memory needs none of it.
package mem_access_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/data_mem_be.sv
// Word-organised data memory with per-byte write enables; contents survive reset.
// Latency: combinational read, write on the rising clock edge.  Backpressure: none.
// The caller owns alignment and lane selection.
module data_mem_be #(
    parameter  int XLEN        = 32,
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS),
    localparam int NB          = XLEN / 8
) (
    input  logic            clk,
    input  logic [AW-1:0]   i_addr,
    input  logic [NB-1:0]   i_be,
    input  logic [XLEN-1:0] i_wdat,
    output logic [XLEN-1:0] o_rdat
);

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdat[b*8 +: 8];
            end
        end
    end

    assign o_rdat = r_mem[i_addr];

endmodule

// File: rtl/mem_access_lsu.sv
// M-stage load/store unit: byte/half/word access to a local data memory, MEM/WB register.
// Latency: one cycle plus LATENCY wait cycles per access; non-accesses take one cycle.
// Backpressure: StallM holds the M stage while waiting; bubbles are written to W meanwhile.
module mem_access_lsu
    import mem_access_lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic            ResultSrcM,
    input  logic            MemWriteM,
    input  logic            MemReadM,
    input  logic [2:0]      Funct3M,
    input  logic [4:0]      RDM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            StallM,
    output logic            MisalignM,
    output logic            RegWriteW,
    output logic            ResultSrcW,
    output logic [4:0]      RDW,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW
);

    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam int         NB  = XLEN / 8;
    localparam logic [3:0] LAT = 4'(LATENCY);

    lsu_state_t      r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic            w_access, w_complete, w_half, w_word;
    logic [1:0]      w_off;
    logic [NB-1:0]   w_be_sel, w_be;
    logic [XLEN-1:0] w_wdat, w_rdat, w_shift, w_ld;
    logic            w_unused;

    assign w_access = MemReadM | MemWriteM;
    assign w_off    = ALUResultM[1:0];
    assign w_half   = (Funct3M == F3_H) || (Funct3M == F3_HU);
    assign w_word   = (Funct3M == F3_W);
    assign MisalignM = w_access & ((w_half & w_off[0]) | (w_word & (w_off != 2'b00)));
    // Address bits above the array wrap around.
    assign w_unused = ^ALUResultM[XLEN-1:AW+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        StallM      = 1'b0;
        w_complete  = 1'b0;
        if (LATENCY == 0) begin
            w_complete = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        StallM      = 1'b1;
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                WAIT: begin
                    if (r_cnt == LAT) begin
                        w_complete  = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        StallM    = 1'b1;
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_be_sel = '0;
        w_wdat   = WriteDataM;
        case (Funct3M)
            F3_B: begin
                w_be_sel = {{(NB-1){1'b0}}, 1'b1} << w_off;
                w_wdat   = {NB{WriteDataM[7:0]}};
            end
            F3_H: begin
                w_be_sel = {{(NB-2){1'b0}}, 2'b11} << w_off;
                w_wdat   = {(NB/2){WriteDataM[15:0]}};
            end
            F3_W:    w_be_sel = '1;
            default: w_be_sel = '0;
        endcase
    end

    // Stores land only on the edge that closes the completion cycle.
    assign w_be = (MemWriteM & w_complete & ~MisalignM & ~rst) ? w_be_sel : '0;

    data_mem_be #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk    (clk),
        .i_addr (ALUResultM[AW+1:2]),
        .i_be   (w_be),
        .i_wdat (w_wdat),
        .o_rdat (w_rdat)
    );

    always_comb begin
        w_shift = w_rdat >> {w_off, 3'b000};
        w_ld    = '0;
        case (Funct3M)
            F3_B:    w_ld = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
            F3_H:    w_ld = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
            F3_W:    w_ld = w_rdat;
            F3_BU:   w_ld = {{(XLEN-8){1'b0}}, w_shift[7:0]};
            F3_HU:   w_ld = {{(XLEN-16){1'b0}}, w_shift[15:0]};
            default: w_ld = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || StallM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            RDW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
        end else begin
            RegWriteW  <= RegWriteM & ~(MemReadM & MisalignM);
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (MemReadM & ~MisalignM) ? w_ld : '0;
        end
    end

endmodule
